qsys_block_onchip_ram_arbiter: RTL and testbench
================================================

# qsys_block_onchip_ram_arbiter

Two-master arbiter and clear sequencer for the 2048x32 single-port on-chip RAM in the Qsys block. It shares the RAM's one port between two Avalon-MM style requesters, m0 (CNN datapath) and m1 (host/Nios side), using round-robin arbitration. It also zero-fills the whole array after reset or on request. The block sits between both masters and the RAM's s1 port.

## Interface
- ADDR_W, 11, word address width; must satisfy DEPTH <= 2^ADDR_W
- DATA_W, 32, data width
- DEPTH, 2048, number of words cleared by the sequencer
- CLEAR_ON_RESET, 1, when 1 the block enters CLEAR on reset release; when 0 it enters ARB
- clk  in  1  single clock for the block and the RAM
- reset_n  in  1  asynchronous, active-low reset
- mN_address  in  ADDR_W  word address (N = 0, 1; same for all mN_ ports below)
- mN_read, mN_write  in  1  command strobes; both high together is illegal
- mN_byteenable  in  DATA_W/8  byte lanes
- mN_writedata  in  DATA_W  write data
- mN_waitrequest  out  1  command not accepted this cycle
- mN_readdata  out  DATA_W  read data
- mN_readdatavalid  out  1  read response strobe
- ram_address, ram_byteenable, ram_writedata  out  ADDR_W / DATA_W/8 / DATA_W  to RAM
- ram_chipselect, ram_write  out  1  to RAM
- ram_readdata  in  DATA_W  from RAM; address is registered inside the RAM, q is unregistered
- clear_req  in  1  single-cycle pulse; requests a full zero-fill
- busy  out  1  high while in CLEAR
- clear_done  out  1  one-cycle pulse on the last clear write

## Operation
- States:
  - CLEAR: counter walks 0..DEPTH-1. Each cycle the RAM sees chipselect=1, write=1, byteenable all ones, writedata 0, address=counter. Both mN_waitrequest=1. After the DEPTH-1 write the block goes to ARB and pulses clear_done.
  - ARB: normal arbitration.
- In ARB a master is requesting when read|write.
  - One requester: it is granted.
  - Both requesting: grant the master other than last_grant.
  - last_grant updates only on a grant; its reset value is 1, so m0 wins the first tie.
- Grant is combinational. The granted master's waitrequest=0 and its command is muxed onto ram_* in the same cycle. The losing or idle master's waitrequest=1. No request gives ram_chipselect=0 and ram_write=0.
- Read tracking: registers rd_valid and rd_owner capture each accepted read. In the following cycle, rd_valid drives mN_readdatavalid for rd_owner only.
- ram_readdata fans out to both mN_readdata unconditionally. Consumers qualify it with readdatavalid.
- clear_req in ARB:
  - The current cycle's grant still completes. A read accepted in that cycle still returns its readdatavalid in the first CLEAR cycle.
  - CLEAR starts on the next cycle with counter=0.
- clear_req in CLEAR is ignored; the counter does not restart.

## Timing
- Reset values: state = CLEAR if CLEAR_ON_RESET, else ARB; counter=0; last_grant=1; rd_valid=0; busy = CLEAR_ON_RESET; clear_done=0. All ram_* strobes are 0 while reset_n=0.
- Reset asserted mid-operation discards any pending readdatavalid and aborts a clear in progress.
- Write latency: a write accepted in cycle N is committed at the end of cycle N.
- Read latency: a read accepted in cycle N returns readdatavalid in cycle N+1, one cycle exactly. Back-to-back reads sustain one per cycle, including alternating masters.
- A read in cycle N+1 to an address written in cycle N returns the new data.
- A clear takes DEPTH cycles. busy is high for exactly those DEPTH cycles.
- Throughput under contention: alternating grants; neither master waits more than 1 cycle.

## Structure
- Shared package qsys_block_pkg: state enum {CLEAR, ARB} and the master-index constants M0=0, M1=1.
- Single module with no sub-module. The round-robin pick is small enough to stay inline.

## Test plan
- Reset with DEPTH=16, CLEAR_ON_RESET=1 -> busy high for 16 cycles, addresses 0..15 written with 0, clear_done pulses in the 16th cycle, then m0 reads at 5 give 0x00000000.
- m0 writes 0xDEADBEEF to 7, then reads 7 in the next cycle -> m0_readdatavalid one cycle later with 0xDEADBEEF; m1_readdatavalid stays 0.
- Both masters issue reads every cycle for 8 cycles -> grants alternate m0,m1,m0,...; each readdatavalid lands on the correct master one cycle after its grant.
- Partial write: m1 writes byteenable=4'b0010, data 0x0000AB00 over 0x11223344 -> readback 0x1122AB44.
- clear_req in the same cycle as an accepted m1 read -> m1_readdatavalid in the next cycle, then 16 CLEAR cycles with both masters in waitrequest; a second clear_req mid-clear does not extend busy.
- reset_n asserted in the cycle a read is accepted -> no readdatavalid follows; the block re-enters CLEAR with counter=0.

Source files
------------

// File: rtl/qsys_block_pkg.sv
// Shared types for the Qsys on-chip RAM arbiter: sequencer states and master indices.
package qsys_block_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/qsys_block_onchip_ram_arbiter_if.sv
// Avalon-MM style requester port shared by both masters of the on-chip RAM arbiter.
interface qsys_block_onchip_ram_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/qsys_block_onchip_ram_arbiter.sv
// Round-robin arbiter for two masters sharing the single-port on-chip RAM,
// with a zero-fill sequencer that runs after reset or on clear_req.
module qsys_block_onchip_ram_arbiter
  import qsys_block_pkg::*;
#(
  parameter int ADDR_W         = 11,
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 2048,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  qsys_block_onchip_ram_arbiter_if.slave m0,
  qsys_block_onchip_ram_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_writedata,
  input  logic [DATA_W-1:0]   ram_readdata,
  input  logic                clear_req,
  output logic                busy,
  output logic                clear_done
);

  localparam state_t            RESET_STATE = CLEAR_ON_RESET ? CLEAR : ARB;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);

  state_t            r_state, w_nextState;
  logic [ADDR_W-1:0] r_count, w_nextCount;
  logic              r_lastGrant, w_nextLastGrant;
  logic              r_rdValid, w_nextRdValid;
  logic              r_rdOwner, w_nextRdOwner;
  logic              w_req0, w_req1, w_grant0, w_grant1;
  logic              w_cs, w_we, w_clearDone;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RESET_STATE;
      r_count     <= '0;
      r_lastGrant <= M1;
      r_rdValid   <= 1'b0;
      r_rdOwner   <= M0;
    end else begin
      r_state     <= w_nextState;
      r_count     <= w_nextCount;
      r_lastGrant <= w_nextLastGrant;
      r_rdValid   <= w_nextRdValid;
      r_rdOwner   <= w_nextRdOwner;
    end
  end

  // On a tie the master that did not win last time gets the port.
  always_comb begin
    w_req0   = m0.read | m0.write;
    w_req1   = m1.read | m1.write;
    w_grant0 = (r_state == ARB) && w_req0 && (!w_req1 || (r_lastGrant == M1));
    w_grant1 = (r_state == ARB) && w_req1 && !w_grant0;
  end

  always_comb begin
    w_nextState     = r_state;
    w_nextCount     = r_count;
    w_nextLastGrant = r_lastGrant;
    w_nextRdValid   = 1'b0;
    w_nextRdOwner   = r_rdOwner;
    w_cs            = 1'b0;
    w_we            = 1'b0;
    w_clearDone     = 1'b0;
    busy            = 1'b0;
    ram_address     = '0;
    ram_byteenable  = '0;
    ram_writedata   = '0;
    m0.waitrequest  = 1'b1;
    m1.waitrequest  = 1'b1;

    case (r_state)
      CLEAR: begin
        busy           = 1'b1;
        w_cs           = 1'b1;
        w_we           = 1'b1;
        ram_address    = r_count;
        ram_byteenable = '1;
        if (r_count == LAST_ADDR) begin
          w_clearDone = 1'b1;
          w_nextCount = '0;
          w_nextState = ARB;
        end else begin
          w_nextCount = r_count + 1'b1;
        end
      end

      ARB: begin
        if (w_grant0) begin
          m0.waitrequest  = 1'b0;
          w_cs            = 1'b1;
          w_we            = m0.write;
          ram_address     = m0.address;
          ram_byteenable  = m0.byteenable;
          ram_writedata   = m0.writedata;
          w_nextLastGrant = M0;
          w_nextRdValid   = m0.read;
          w_nextRdOwner   = M0;
        end else if (w_grant1) begin
          m1.waitrequest  = 1'b0;
          w_cs            = 1'b1;
          w_we            = m1.write;
          ram_address     = m1.address;
          ram_byteenable  = m1.byteenable;
          ram_writedata   = m1.writedata;
          w_nextLastGrant = M1;
          w_nextRdValid   = m1.read;
          w_nextRdOwner   = M1;
        end
        // The grant above still completes; the zero-fill begins next cycle.
        if (clear_req) begin
          w_nextState = CLEAR;
          w_nextCount = '0;
        end
      end

      default: w_nextState = RESET_STATE;
    endcase
  end

  // Strobes are forced low while reset is held so the RAM is never touched.
  assign ram_chipselect = w_cs & reset_n;
  assign ram_write      = w_we & reset_n;
  assign clear_done     = w_clearDone & reset_n;

  assign m0.readdata      = ram_readdata;
  assign m1.readdata      = ram_readdata;
  assign m0.readdatavalid = r_rdValid && (r_rdOwner == M0);
  assign m1.readdatavalid = r_rdValid && (r_rdOwner == M1);

endmodule

// File: tb/tb_qsys_block_onchip_ram_arbiter.sv
// Scoreboard bench for the on-chip RAM arbiter: a word-level reference model
// predicts grants and read responses, a negedge monitor checks the responses.
module tb_qsys_block_onchip_ram_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [10:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } cmd_t;

  typedef struct {
    int          owner;
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              clear_req = 1'b0;
  logic              busy, clear_done;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect, ram_write;
  logic [3:0]        ram_byteenable;
  logic [31:0]       ram_writedata, ram_readdata;

  qsys_block_onchip_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0If();
  qsys_block_onchip_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1If();

  qsys_block_onchip_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .m0(m0If), .m1(m1If),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_byteenable(ram_byteenable),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata),
    .clear_req(clear_req), .busy(busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  // RAM: registered address, unregistered q, byte-lane writes at the clock edge.
  logic [31:0]       ramMem [2048];
  logic [ADDR_W-1:0] ramAddrReg = '0;
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write)
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) ramMem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
      ramAddrReg <= ram_address;
    end
  end
  assign ram_readdata = ramMem[ramAddrReg];

  int          checks = 0;
  int          errors = 0;
  int          cycleCnt = 0;
  rsp_t        expQ[$];
  logic [31:0] refMem [32];
  int          modelLast = 1;
  int          clearLeft = 0;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  function automatic cmd_t idleCmd();
    return '0;
  endfunction

  function automatic cmd_t rdCmd(input int a);
    cmd_t c = '0;
    c.rd = 1'b1; c.addr = 11'(a); c.be = 4'hF;
    return c;
  endfunction

  function automatic cmd_t wrCmd(input int a, input logic [3:0] be, input logic [31:0] d);
    cmd_t c = '0;
    c.wr = 1'b1; c.addr = 11'(a); c.be = be; c.data = d;
    return c;
  endfunction

  function automatic logic [31:0] mergeBe(input logic [31:0] oldW, input logic [31:0] newW,
                                          input logic [3:0] be);
    logic [31:0] r = oldW;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = newW[b*8 +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // Read responses: one per valid strobe, on the right master, one cycle after acceptance.
  rsp_t        monE;
  int          monOwner;
  logic [31:0] monData;
  always @(negedge clk) begin
    if (m0If.readdatavalid && m1If.readdatavalid) begin
      checkOutput("bothValid", 64'd1, 64'd0);
    end else if (m0If.readdatavalid || m1If.readdatavalid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedValid", {m0If.readdatavalid, m1If.readdatavalid}, 64'd0);
      end else begin
        monE     = expQ.pop_front();
        monOwner = m1If.readdatavalid ? 1 : 0;
        monData  = m1If.readdatavalid ? m1If.readdata : m0If.readdata;
        checkOutput("rspOwner", 64'(monOwner), 64'(monE.owner));
        checkOutput("rspData", 64'(monData), 64'(monE.data));
        checkOutput("rspCycle", 64'(cycleCnt), 64'(monE.cyc));
      end
    end else if (expQ.size() > 0 && expQ[0].cyc <= cycleCnt) begin
      monE = expQ.pop_front();
      checkOutput("missingValid", 64'd0, 64'd1);
    end
  end

  // Drives one cycle of commands and predicts grant, RAM bus and responses.
  task automatic applyStimulus(input cmd_t c0, input cmd_t c1, input logic clr);
    int   win;
    int   prevLeft;
    cmd_t c;
    @(posedge clk); #1;
    m0If.read = c0.rd; m0If.write = c0.wr; m0If.address = c0.addr;
    m0If.byteenable = c0.be; m0If.writedata = c0.data;
    m1If.read = c1.rd; m1If.write = c1.wr; m1If.address = c1.addr;
    m1If.byteenable = c1.be; m1If.writedata = c1.data;
    clear_req = clr;
    #1;
    prevLeft = clearLeft;
    if (prevLeft > 0) begin
      checkOutput("clearStatus", {busy, clear_done, m0If.waitrequest, m1If.waitrequest},
                  {1'b1, prevLeft == 1, 1'b1, 1'b1});
      checkOutput("clearBus",
                  {ram_chipselect, ram_write, ram_address, ram_byteenable, ram_writedata},
                  {1'b1, 1'b1, 11'(DEPTH - prevLeft), 4'hF, 32'h0});
      clearLeft--;
    end else begin
      if ((c0.rd | c0.wr) && (c1.rd | c1.wr)) win = 1 - modelLast;
      else if (c0.rd | c0.wr)                 win = 0;
      else if (c1.rd | c1.wr)                 win = 1;
      else                                    win = -1;
      checkOutput("arbStatus", {busy, clear_done, m0If.waitrequest, m1If.waitrequest},
                  {1'b0, 1'b0, win != 0, win != 1});
      if (win >= 0) begin
        c = (win == 0) ? c0 : c1;
        checkOutput("ramMux",
                    {ram_chipselect, ram_write, ram_address, ram_byteenable, ram_writedata},
                    {1'b1, c.wr, c.addr, c.be, c.data});
        modelLast = win;
        if (c.rd) begin
          rsp_t r;
          r.owner = win; r.data = refMem[c.addr[4:0]]; r.cyc = cycleCnt + 1;
          expQ.push_back(r);
        end
        if (c.wr) refMem[c.addr[4:0]] = mergeBe(refMem[c.addr[4:0]], c.data, c.be);
      end else begin
        checkOutput("ramIdle", {ram_chipselect, ram_write}, 2'b00);
      end
      if (clr) begin
        clearLeft = DEPTH;
        for (int i = 0; i < DEPTH; i++) refMem[i] = 32'h0;
      end
    end
  endtask

  // Called in the first cycle after reset release; walks the whole zero-fill.
  task automatic checkClear();
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      #1;
      checkOutput("resetClear",
                  {busy, clear_done, m0If.waitrequest, m1If.waitrequest,
                   ram_chipselect, ram_write, ram_address, ram_byteenable, ram_writedata},
                  {1'b1, i == DEPTH - 1, 1'b1, 1'b1, 1'b1, 1'b1, 11'(i), 4'hF, 32'h0});
    end
    @(posedge clk); #2;
    checkOutput("clearEnd", {busy, clear_done}, 2'b00);
    clearLeft = 0;
    modelLast = 1;
    for (int i = 0; i < DEPTH; i++) refMem[i] = 32'h0;
  endtask

  task automatic driveIdle();
    m0If.read = 0; m0If.write = 0; m0If.address = '0; m0If.byteenable = '0; m0If.writedata = '0;
    m1If.read = 0; m1If.write = 0; m1If.address = '0; m1If.byteenable = '0; m1If.writedata = '0;
    clear_req = 0;
  endtask

  initial begin
    cmd_t c0, c1;
    driveIdle();
    for (int i = 0; i < 32; i++) refMem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("resetState",
                {ram_chipselect, ram_write, busy, clear_done,
                 m0If.readdatavalid, m1If.readdatavalid}, 6'b001000);
    @(posedge clk); #1;
    reset_n = 1'b1;
    checkClear();

    applyStimulus(rdCmd(5), idleCmd(), 1'b0);
    applyStimulus(idleCmd(), idleCmd(), 1'b0);

    applyStimulus(wrCmd(7, 4'hF, 32'hDEADBEEF), idleCmd(), 1'b0);
    applyStimulus(rdCmd(7), idleCmd(), 1'b0);
    applyStimulus(idleCmd(), idleCmd(), 1'b0);

    for (int i = 0; i < 8; i++) applyStimulus(rdCmd(i), rdCmd(8 + i), 1'b0);
    applyStimulus(idleCmd(), idleCmd(), 1'b0);

    applyStimulus(idleCmd(), wrCmd(9, 4'hF, 32'h11223344), 1'b0);
    applyStimulus(idleCmd(), wrCmd(9, 4'b0010, 32'h0000AB00), 1'b0);
    applyStimulus(idleCmd(), rdCmd(9), 1'b0);
    applyStimulus(idleCmd(), idleCmd(), 1'b0);

    for (int a = 16; a < 32; a++) applyStimulus(idleCmd(), wrCmd(a, 4'hF, $urandom), 1'b0);

    // Clear requested alongside an accepted m1 read, then a second request mid-clear.
    applyStimulus(idleCmd(), rdCmd(9), 1'b1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(rdCmd(1), rdCmd(2), i == 5);
    applyStimulus(idleCmd(), idleCmd(), 1'b0);

    for (int n = 0; n < 400; n++) begin
      int k0, k1;
      k0 = $urandom_range(0, 2);
      k1 = $urandom_range(0, 2);
      c0 = (k0 == 0) ? idleCmd() : (k0 == 1) ? rdCmd($urandom_range(0, 31))
         : wrCmd($urandom_range(0, 31), 4'($urandom), $urandom);
      c1 = (k1 == 0) ? idleCmd() : (k1 == 1) ? rdCmd($urandom_range(0, 31))
         : wrCmd($urandom_range(0, 31), 4'($urandom), $urandom);
      applyStimulus(c0, c1, $urandom_range(0, 99) == 0);
    end
    repeat (DEPTH + 3) applyStimulus(idleCmd(), idleCmd(), 1'b0);

    // Reset lands in the cycle a read is granted: no response may follow.
    @(posedge clk); #1;
    m0If.read = 1'b1; m0If.address = 11'd3; m0If.byteenable = 4'hF;
    #1;
    reset_n = 1'b0;
    #1;
    driveIdle();
    checkOutput("resetStrobes", {ram_chipselect, ram_write, busy}, 3'b001);
    @(posedge clk); #2;
    checkOutput("noValidAfterReset", {m0If.readdatavalid, m1If.readdatavalid}, 2'b00);
    @(posedge clk); #1;
    reset_n = 1'b1;
    checkClear();
    applyStimulus(rdCmd(3), rdCmd(20), 1'b0);
    applyStimulus(idleCmd(), idleCmd(), 1'b0);
    applyStimulus(idleCmd(), idleCmd(), 1'b0);

    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
